// File: rtl/shwr_param_capture_pkg.sv
// Package for the shower parameter capture block: field widths derived
// from the trigger defines, FSM state encoding and the word packer.
`include "sde_trigger_defs.vh"

package shwr_param_capture_pkg;

    localparam int ADC_W    = `ADC_WIDTH;
    localparam int SBASE_W  = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;
    localparam int AREA_W   = `SHWR_AREA_WIDTH;
    localparam int WORD_W   = `SHWR_PARAM_WORD_WIDTH;
    localparam int DONE_DEF = `SHWR_DONE_CNT;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [7:0]         seq,
        input logic               trunc,
        input logic               sat,
        input logic [SBASE_W-1:0] sbase,
        input logic [ADC_W-1:0]   peak,
        input logic [AREA_W-1:0]  area
    );
        return {seq, trunc, sat, sbase, peak, area};
    endfunction

endpackage

// File: rtl/sde_trigger_defs.vh
// Shared widths for the surface-detector shower trigger path.
`ifndef SDE_TRIGGER_DEFS_VH
`define SDE_TRIGGER_DEFS_VH

`define ADC_WIDTH                12
`define SHWR_BASELINE_EXTRA_BITS 2
`define SHWR_AREA_WIDTH          19
`define SHWR_AREA_BINS           16

// Integrator outputs settle a few cycles after the last area bin.
`define SHWR_DONE_CNT            (`SHWR_AREA_BINS+4)

// {SEQ[7:0], TRUNC, SATURATED, SBASELINE, PEAK, INTEGRAL}
`define SHWR_PARAM_WORD_WIDTH    (8+2+`ADC_WIDTH*2+`SHWR_BASELINE_EXTRA_BITS+`SHWR_AREA_WIDTH)

`endif

// File: rtl/shwr_param_fifo.sv
// Show-ahead FIFO for captured shower parameter words.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   wr_en/wr_data - push; accepted when not full or when a pop happens
//                   on the same edge
//   rd_en         - pop; ignored while empty
//   rd_valid      - FIFO non-empty
//   rd_data       - head word (zero while empty)
//   full          - occupancy equals DEPTH
module shwr_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indexes match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, push, pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = rd_en && !empty;
        push     = wr_en && (!full || pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        rd_valid = !empty;
        // Masking keeps the head at zero after reset without clearing storage.
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/shwr_param_capture.sv
// Captures the shower integrator results once per TRIGGERED window and
// queues them as tagged words for readout.
// Ports:
//   CLK120, RESET        - clock, asynchronous active-high reset
//   TRIGGERED            - shower window
//   INTEGRAL/PEAK/SBASELINE/SATURATED - integrator results, sampled on capture
//   RD_EN, RD_VALID, RD_DATA - show-ahead readout
//   CLR_OVF, OVF_CNT     - dropped-capture counter (saturating) and its clear
module shwr_param_capture
    import shwr_param_capture_pkg::*;
#(
    parameter int DONE_CNT   = DONE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               CLK120,
    input  logic               RESET,
    input  logic               TRIGGERED,
    input  logic [AREA_W-1:0]  INTEGRAL,
    input  logic [ADC_W-1:0]   PEAK,
    input  logic [SBASE_W-1:0] SBASELINE,
    input  logic               SATURATED,
    input  logic               RD_EN,
    input  logic               CLR_OVF,
    output logic               RD_VALID,
    output logic [WORD_W-1:0]  RD_DATA,
    output logic [7:0]         OVF_CNT
);

    localparam int CNT_W = $clog2(DONE_CNT + 1);
    localparam logic [CNT_W-1:0] DONE_V = CNT_W'(DONE_CNT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             capture, trunc, drop, fifo_full;
    logic [WORD_W-1:0] word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        trunc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TRIGGERED) begin
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!TRIGGERED) begin
                    // Window ended before the integrator settled.
                    capture = 1'b1;
                    trunc   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q < DONE_V) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!TRIGGERED) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // SEQ advances on every attempt so gaps reveal dropped words.
        seq_d = capture ? seq_q + 8'd1 : seq_q;
        word  = pack_word(seq_q, trunc, SATURATED, SBASELINE, PEAK, INTEGRAL);

        // A pop on the same edge frees the slot, so only an unpopped full FIFO drops.
        drop  = capture && fifo_full && !RD_EN;
        if (CLR_OVF)
            ovf_d = {7'd0, drop};
        else if (drop && ovf_q != 8'hFF)
            ovf_d = ovf_q + 8'd1;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OVF_CNT = ovf_q;

    shwr_param_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK120),
        .rst      (RESET),
        .wr_en    (capture),
        .wr_data  (word),
        .rd_en    (RD_EN),
        .rd_valid (RD_VALID),
        .rd_data  (RD_DATA),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_shwr_param_capture.sv
module tb_shwr_param_capture;
    import shwr_param_capture_pkg::*;

    localparam int DCNT  = 20;
    localparam int DEPTH = 4;

    logic               clk   = 1'b0;
    logic               rst   = 1'b1;
    logic               trig  = 1'b0;
    logic               sat   = 1'b0;
    logic               rd_en = 1'b0;
    logic               clr   = 1'b0;
    logic [AREA_W-1:0]  integ = '0;
    logic [ADC_W-1:0]   peak  = '0;
    logic [SBASE_W-1:0] sbase = '0;
    logic               rd_valid;
    logic [WORD_W-1:0]  rd_data;
    logic [7:0]         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shwr_param_capture #(
        .DONE_CNT   (DCNT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK120    (clk),
        .RESET     (rst),
        .TRIGGERED (trig),
        .INTEGRAL  (integ),
        .PEAK      (peak),
        .SBASELINE (sbase),
        .SATURATED (sat),
        .RD_EN     (rd_en),
        .CLR_OVF   (clr),
        .RD_VALID  (rd_valid),
        .RD_DATA   (rd_data),
        .OVF_CNT   (ovf)
    );

    // Expected word: {SEQ, TRUNC, SAT, SBASELINE[13:0], PEAK[11:0], INTEGRAL[18:0]}
    function automatic logic [WORD_W-1:0] mk(input int seq, input int tr, input int st,
                                             input int sb, input int pk, input int ig);
        logic [WORD_W-1:0] w;
        w = '0;
        w[18:0]  = ig[18:0];
        w[30:19] = pk[11:0];
        w[44:31] = sb[13:0];
        w[45]    = st[0];
        w[46]    = tr[0];
        w[54:47] = seq[7:0];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        trig  = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        rst   = 1'b1;
        #3;
        rst   = 1'b0;
        tick();
    endtask

    // Short window: n edges high, then the truncating capture edge, then idle.
    task automatic window(input int n);
        trig = 1'b1;
        repeat (n) tick();
        trig = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Full window: capture on the 21st high edge, visible right after
        integ = 1234; peak = 100; sbase = 2000; sat = 0;
        trig  = 1'b1;
        repeat (20) tick();
        chk("full_pre_valid", rd_valid, 0);
        tick();
        chk("full_valid", rd_valid, 1);
        chk("full_word", rd_data, mk(0, 0, 0, 2000, 100, 1234));
        integ = 9;
        repeat (39) tick();
        trig = 1'b0;
        tick(); tick();
        chk("full_head_kept", rd_data, mk(0, 0, 0, 2000, 100, 1234));
        pop();
        chk("full_single_word", rd_valid, 0);

        // Short window, captured on the falling edge with a pop into an empty FIFO
        integ = 555; peak = 7; sbase = 300; sat = 1;
        trig  = 1'b1;
        repeat (7) tick();
        chk("short_pre_valid", rd_valid, 0);
        trig  = 1'b0;
        integ = 777;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("short_valid", rd_valid, 1);
        chk("short_word", rd_data, mk(1, 1, 1, 300, 7, 777));
        pop();
        chk("short_empty", rd_valid, 0);

        // Overflow: six windows, no reads
        do_reset();
        sat = 0; integ = 10;
        repeat (6) window(3);
        chk("ovf_two", ovf, 2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_seq%0d", i), rd_data[WORD_W-1 -: 8], i);
            pop();
        end
        chk("ovf_drained", rd_valid, 0);
        window(3);
        chk("ovf_next_seq", rd_data[WORD_W-1 -: 8], 6);
        pop();

        // Full FIFO with simultaneous pop and capture
        do_reset();
        repeat (4) window(3);
        chk("fullpop_pre_ovf", ovf, 0);
        trig = 1'b1;
        repeat (3) tick();
        trig  = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        chk("fullpop_ovf", ovf, 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("fullpop_seq%0d", i), rd_data[WORD_W-1 -: 8], i);
            pop();
        end
        chk("fullpop_drained", rd_valid, 0);

        // CLR_OVF with a drop, plain clear, saturation, SEQ wrap
        do_reset();
        repeat (6) window(3);
        chk("clr_pre", ovf, 2);
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        clr  = 1'b1;
        tick();
        clr  = 1'b0;
        chk("clr_with_drop", ovf, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_plain", ovf, 0);
        for (int i = 0; i < 300; i++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            tick();
        end
        chk("ovf_sat", ovf, 255);
        repeat (4) pop();
        chk("sat_drained", rd_valid, 0);
        window(3);
        chk("seq_wrap", rd_data[WORD_W-1 -: 8], 51);
        pop();

        // Reset in the middle of a window with two words buffered
        do_reset();
        repeat (2) window(3);
        chk("midrst_buffered", rd_valid, 1);
        integ = 4321; peak = 55; sbase = 1000; sat = 0;
        trig = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_data", rd_data, 0);
        #1;
        rst = 1'b0;
        repeat (20) tick();
        chk("midrst_no_early", rd_valid, 0);
        tick();
        chk("midrst_new_valid", rd_valid, 1);
        chk("midrst_new_word", rd_data, mk(0, 0, 0, 1000, 55, 4321));
        trig = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
